// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: opcodes, FSM states,
// accumulator source selects and the decoded control word.
package bip_pkg;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_JMP  = 5'b01000;
  localparam logic [4:0] OP_BZ   = 5'b01001;

  localparam logic [1:0] SEL_RAM = 2'd0;
  localparam logic [1:0] SEL_IMM = 2'd1;
  localparam logic [1:0] SEL_ALU = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_IMM,
    CLS_MEM,
    CLS_STORE,
    CLS_HALT,
    CLS_BRANCH
  } op_class_t;

  // cond marks a branch that is taken only when the accumulator is zero
  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op_sub;
    op_class_t  cls;
    logic       cond;
  } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Opcode to control-word mapping. JMP/BZ decode only when BIP_BRANCH_EN is
// defined; otherwise they fall through to NOP like any undefined opcode.
module bip_decoder
  import bip_pkg::*;
(
  input  logic [4:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '{sel_a: SEL_RAM, sel_b: 1'b0, op_sub: 1'b0, cls: CLS_NOP, cond: 1'b0};
    case (opcode)
      OP_HLT:  ctrl.cls = CLS_HALT;
      OP_STO:  ctrl.cls = CLS_STORE;
      OP_LD:   ctrl.cls = CLS_MEM;
      OP_LDI: begin
        ctrl.cls   = CLS_IMM;
        ctrl.sel_a = SEL_IMM;
      end
      OP_ADD: begin
        ctrl.cls   = CLS_MEM;
        ctrl.sel_a = SEL_ALU;
      end
      OP_ADDI: begin
        ctrl.cls   = CLS_IMM;
        ctrl.sel_a = SEL_ALU;
        ctrl.sel_b = 1'b1;
      end
      OP_SUB: begin
        ctrl.cls    = CLS_MEM;
        ctrl.sel_a  = SEL_ALU;
        ctrl.op_sub = 1'b1;
      end
      OP_SUBI: begin
        ctrl.cls    = CLS_IMM;
        ctrl.sel_a  = SEL_ALU;
        ctrl.sel_b  = 1'b1;
        ctrl.op_sub = 1'b1;
      end
`ifdef BIP_BRANCH_EN
      OP_JMP:  ctrl.cls = CLS_BRANCH;
      OP_BZ: begin
        ctrl.cls  = CLS_BRANCH;
        ctrl.cond = 1'b1;
      end
`endif
      default: ctrl.cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// BIP instruction sequencer: PC, IR and the FETCH/DECODE/EXEC/MEM/HALT FSM.
// Optional BIP_BRANCH_EN adds the acc_zero port and JMP/BZ.
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int PC_W     = 11,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               instr_valid,
`ifdef BIP_BRANCH_EN
  input  logic               acc_zero,
`endif
  output logic [PC_W-1:0]    address_output,
  output logic               instr_req,
  output logic [PC_W-1:0]    operand,
  output logic [1:0]         sel_a,
  output logic               sel_b,
  output logic               op_sub,
  output logic               wr_acc,
  output logic               rd_ram,
  output logic               wr_ram,
  output logic               halted
);

  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0]    pc;
  ctrl_t              ctrl;
  logic               zero_flag;

`ifdef BIP_BRANCH_EN
  assign zero_flag = acc_zero;
`else
  assign zero_flag = 1'b0;
`endif

  bip_decoder u_decoder (
    .opcode (ir[INSTR_W-1:PC_W]),
    .ctrl   (ctrl)
  );

  assign address_output = pc;
  assign operand        = ir[PC_W-1:0];

  // Strobes are registered one edge ahead so each is high for exactly the
  // EXEC or MEM cycle it belongs to; the default clears them every edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_FETCH;
      pc        <= PC_W'(RESET_PC);
      ir        <= '0;
      instr_req <= 1'b1;
      sel_a     <= SEL_RAM;
      sel_b     <= 1'b0;
      op_sub    <= 1'b0;
      wr_acc    <= 1'b0;
      rd_ram    <= 1'b0;
      wr_ram    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      sel_a  <= SEL_RAM;
      sel_b  <= 1'b0;
      op_sub <= 1'b0;
      wr_acc <= 1'b0;
      rd_ram <= 1'b0;
      wr_ram <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (instr_valid) begin
            ir        <= instr_data;
            instr_req <= 1'b0;
            state     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state <= ST_EXEC;
          case (ctrl.cls)
            CLS_IMM: begin
              wr_acc <= 1'b1;
              sel_a  <= ctrl.sel_a;
              sel_b  <= ctrl.sel_b;
              op_sub <= ctrl.op_sub;
            end
            CLS_STORE: wr_ram <= 1'b1;
            CLS_MEM:   rd_ram <= 1'b1;
            CLS_HALT:  halted <= 1'b1;
            default: ;
          endcase
        end
        ST_EXEC: begin
          case (ctrl.cls)
            CLS_MEM: begin
              state  <= ST_MEM;
              wr_acc <= 1'b1;
              sel_a  <= ctrl.sel_a;
              sel_b  <= ctrl.sel_b;
              op_sub <= ctrl.op_sub;
            end
            CLS_HALT: state <= ST_HALT;
            CLS_BRANCH: begin
              pc        <= (!ctrl.cond || zero_flag) ? operand : pc + 1'b1;
              instr_req <= 1'b1;
              state     <= ST_FETCH;
            end
            default: begin
              pc        <= pc + 1'b1;
              instr_req <= 1'b1;
              state     <= ST_FETCH;
            end
          endcase
        end
        ST_MEM: begin
          pc        <= pc + 1'b1;
          instr_req <= 1'b1;
          state     <= ST_FETCH;
        end
        ST_HALT: ;
        default: begin
          instr_req <= 1'b1;
          state     <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/bip_control_unit.md
# bip_control_unit

Multi-cycle instruction sequencer for the BIP accumulator processor. Owns the program counter, fetches 16-bit instructions from program memory over a valid handshake, decodes them and drives the one-cycle control strobes for the accumulator, ALU and data RAM. Sits between program memory and the accumulator/ALU/RAM datapath as the processor's only control source.

## Interface
- `PC_W`, 11, program counter and operand width
- `INSTR_W`, 16, instruction width: opcode [15:11], operand [10:0]
- `RESET_PC`, 0, PC value loaded at reset
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, synchronous and active-low
- `instr_data` in 16: instruction word from program memory
- `instr_valid` in 1: `instr_data` valid for the current `address_output`
- `acc_zero` in 1: accumulator equals zero; present only with `BIP_BRANCH_EN`
- `address_output` out 11: program counter, program memory address
- `instr_req` out 1: fetch request
- `operand` out 11: IR[10:0], RAM address or immediate
- `sel_a` out 2: accumulator source: 0 RAM data, 1 immediate, 2 ALU result
- `sel_b` out 1: ALU B input: 0 RAM data, 1 immediate
- `op_sub` out 1: ALU operation: 0 add, 1 subtract
- `wr_acc` out 1: accumulator write strobe
- `rd_ram` out 1: RAM read strobe
- `wr_ram` out 1: RAM write strobe, accumulator to `operand`
- `halted` out 1: processor stopped

## Operation
- Opcodes: HLT 00000, STO 00001, LD 00010, LDI 00011, ADD 00100, ADDI 00101, SUB 00110, SUBI 00111.
- FSM states: FETCH, DECODE, EXEC, MEM, HALT. Reset enters FETCH.
- FETCH: `instr_req`=1. When `instr_valid`=1 at an edge, IR takes `instr_data` and the FSM goes to DECODE. Otherwise it stays in FETCH with no timeout.
- DECODE: the control word is computed from IR. No strobes are asserted. The FSM goes to EXEC.
- EXEC:
  - LDI, ADDI, SUBI: `wr_acc` pulses with the selectors for that opcode. PC+1. Go to FETCH.
  - STO: `wr_ram` pulses. PC+1. Go to FETCH.
  - LD, ADD, SUB: `rd_ram` pulses. Go to MEM.
  - HLT: go to HALT. PC is not incremented.
  - Undefined opcodes behave as NOP: PC+1, go to FETCH.
- MEM: `wr_acc` pulses with that opcode's `sel_a`, `sel_b` and `op_sub`. PC+1. Go to FETCH.
- Selector values:
  - LD: `sel_a`=0
  - LDI: `sel_a`=1
  - ADD: `sel_a`=2, `sel_b`=0, `op_sub`=0
  - ADDI: `sel_a`=2, `sel_b`=1, `op_sub`=0
  - SUB and SUBI: as ADD and ADDI with `op_sub`=1
- HALT: `halted`=1. All strobes are 0. The only exit is reset.
- PC arithmetic is modulo 2^11: 2047+1 wraps to 0.
- `instr_valid` is ignored outside FETCH.

## Timing
- Reset values: `address_output`=`RESET_PC`, IR=0. `instr_req` is 1 because reset enters FETCH. All other outputs are 0.
- All outputs are registered or decoded from state and IR only. There is no combinational path from any input to any output.
- Each strobe is high for exactly one cycle per instruction.
- With zero-wait memory (`instr_valid` high in the first FETCH cycle):
  - Immediate ops, STO, NOP: 3 cycles.
  - LD, ADD, SUB: 4 cycles.
  - Each wait cycle in FETCH adds one cycle.
- `address_output` updates on the edge that leaves EXEC (non-memory ops) or MEM (memory ops). It is stable throughout FETCH.
- `rst_n` low at any edge, in any state, forces the reset values on that edge. A strobe asserted in that cycle does not repeat.

## Configuration
- `BIP_BRANCH_EN` defined:
  - Adds the `acc_zero` port.
  - Adds JMP 01000: in EXEC, PC takes `operand`.
  - Adds BZ 01001: in EXEC, PC takes `operand` if `acc_zero`=1, otherwise PC+1.
  - Both take 3 cycles and assert no strobes.
- `BIP_BRANCH_EN` undefined: no `acc_zero` port, and 01000 and 01001 decode as NOP.

## Structure
- Package `bip_pkg`: opcode constants, FSM state encoding, `sel_a` constants (SEL_RAM, SEL_IMM, SEL_ALU), and a control-word struct holding `sel_a`, `sel_b`, `op_sub` and the opcode class (imm, mem, store, halt, branch).
- Sub-module `bip_decoder`: combinational mapping from IR opcode to control word. The FSM, PC and IR stay in `bip_control_unit`.

## Test plan
- Reset then program LDI 5, HLT with zero-wait memory:
  - `wr_acc` pulses in cycle 3 with `sel_a`=1 and `operand`=5.
  - `address_output` goes 0, 1.
  - `halted`=1 from cycle 6 onward and `address_output` stays 1.
- ADD 0x010 at address 4:
  - `rd_ram` at the EXEC cycle, then `wr_acc` with `sel_a`=2, `sel_b`=0, `op_sub`=0 in the next cycle.
  - `address_output` becomes 5 after 4 cycles.
- `instr_valid` held low 3 cycles during FETCH of STO 0x7FF:
  - `instr_req` is held and `address_output` is stable.
  - `wr_ram` pulses once with `operand`=0x7FF, 6 cycles after the fetch starts.
- PC at 2047 executing SUBI 1 → `op_sub`=1, `sel_b`=1, then `address_output` wraps to 0.
- `rst_n` low during MEM of LD → next cycle `wr_acc`=0 and `address_output`=0, and FETCH restarts from 0.
- With `BIP_BRANCH_EN`:
  - BZ 0x100 with `acc_zero`=1 gives PC=0x100.
  - With `acc_zero`=0, PC = old PC + 1.
  - JMP 0x7FF gives PC=0x7FF.
  - No strobes are asserted in either case.
